rvvi_frame_decoder: RTL and testbench

// - Parametrised successor to the 32-bit RVVI frame scanner. Parses AXI read-channel Ethernet frames of width DATA_WIDTH.
// - Checks the MAC/EtherType header and extracts FrameCount, Minstret and InterPacketDelay.
// - Presents each accepted frame through a one-entry valid/ready output register.
// - Adds sequence-gap detection plus saturating counters for short, mismatched and overflowed frames.
// - Sits between the Ethernet RX DMA/AXI port and the RVVI pacing/compare logic.
//

---
 rtl/rvvi_frame_decoder_pkg.sv | 18 +
 rtl/rvvi_sat_counter.sv | 15 +
 rtl/rvvi_frame_decoder.sv | 122 ++++++++++++
 tb/tb_rvvi_frame_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_frame_decoder_pkg.sv
// rvvi_frame_decoder_pkg: shared types, header layout and helpers for the RVVI frame decoder
package rvvi_frame_decoder_pkg;
    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;
    localparam cvw_t CVW_DEFAULT = '{XLEN: 64};
    localparam int RVVI_HDR_BYTES = 28;
    localparam int RVVI_DST_OFF = 0;
    localparam int RVVI_SRC_OFF = 6;
    localparam int RVVI_TYPE_OFF = 12;
    localparam int RVVI_FCNT_OFF = 14;
    localparam int RVVI_MINSTR_OFF = 16;
    localparam int RVVI_IPD_OFF = 24;
    typedef enum logic [1:0] {COLLECT, CHECK, DRAIN} rvvi_dec_state_t;
    function automatic int rvvi_hdr_beats(input int data_width);
        return (RVVI_HDR_BYTES * 8 + data_width - 1) / data_width;
    endfunction
endpackage

// File: rtl/rvvi_sat_counter.sv
// rvvi_sat_counter: statistics counter that sticks at all-ones instead of wrapping
module rvvi_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] q
);
    // count enabled events until every bit is set
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (en && !(&q)) q <= q + WIDTH'(1);
    end
endmodule

// File: rtl/rvvi_frame_decoder.sv
// rvvi_frame_decoder: parses RVVI Ethernet frames and presents header fields through a valid/ready register
module rvvi_frame_decoder
    import rvvi_frame_decoder_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT,
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_COUNT_WIDTH = 16,
    parameter int STAT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        RvviAxiRdata,
    input  logic [DATA_WIDTH/8-1:0]      RvviAxiRstrb,
    input  logic                         RvviAxiRlast,
    input  logic                         RvviAxiRvalid,
    input  logic [47:0]                  DstMac,
    input  logic [47:0]                  SrcMac,
    input  logic [15:0]                  EthType,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [P.XLEN-1:0]            Minstr,
    output logic [31:0]                  InterPacketDelay,
    output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
    output logic                         SeqErr,
    output logic [STAT_WIDTH-1:0]        ShortCnt,
    output logic [STAT_WIDTH-1:0]        MismatchCnt,
    output logic [STAT_WIDTH-1:0]        OverflowCnt
);
    localparam int XLEN = int'(P.XLEN);
    localparam int HDR_BEATS = rvvi_hdr_beats(DATA_WIDTH);
    localparam int IW = $clog2(HDR_BEATS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(HDR_BEATS - 1);
    localparam logic [IW-1:0] SAT_IDX = IW'(HDR_BEATS);

    rvvi_dec_state_t state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [DATA_WIDTH-1:0] cap_q [HDR_BEATS];
    logic [HDR_BEATS*DATA_WIDTH-1:0] hdr;
    logic [FRAME_COUNT_WIDTH-1:0] fc_new;
    logic end_q, first_q;
    logic rx_last, hdr_done, match, load, short_en, mismatch_en, overflow_en;
    logic unused_bits;

    assign rx_last = RvviAxiRvalid && RvviAxiRlast;
    assign hdr_done = state_q == COLLECT && RvviAxiRvalid && idx_q == LAST_IDX;

    for (genvar g = 0; g < HDR_BEATS; g++) begin : g_hdr
        assign hdr[g*DATA_WIDTH +: DATA_WIDTH] = cap_q[g];
    end

    assign match = hdr[8*RVVI_DST_OFF +: 48] == DstMac && hdr[8*RVVI_SRC_OFF +: 48] == SrcMac
                   && hdr[8*RVVI_TYPE_OFF +: 16] == EthType;
    assign fc_new = hdr[8*RVVI_FCNT_OFF +: FRAME_COUNT_WIDTH];
    assign unused_bits = ^{RvviAxiRstrb, hdr};

    // header beats land in the slot selected by the beat index while collecting
    always_ff @(posedge clk) begin
        for (int i = 0; i < HDR_BEATS; i++)
            if (state_q == COLLECT && RvviAxiRvalid && idx_q == IW'(i)) cap_q[i] <= RvviAxiRdata;
    end

    // parser state, saturating beat index and "frame ended on the last header beat" flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            idx_q <= '0;
            end_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= rx_last ? '0 : (RvviAxiRvalid && idx_q != SAT_IDX) ? idx_q + IW'(1) : idx_q;
            end_q <= hdr_done && RvviAxiRlast;
        end
    end

    // next state and the single-cycle result events raised while checking
    always_comb begin
        state_d = state_q;
        short_en = 1'b0;
        mismatch_en = 1'b0;
        overflow_en = 1'b0;
        load = 1'b0;
        case (state_q)
            COLLECT: begin
                state_d = hdr_done ? CHECK : COLLECT;
                short_en = rx_last && idx_q != LAST_IDX;
            end
            CHECK: begin
                state_d = (end_q || rx_last) ? COLLECT : DRAIN;
                mismatch_en = !match;
                load = match && (!OutValid || OutReady);
                overflow_en = match && OutValid && !OutReady;
            end
            DRAIN: state_d = rx_last ? COLLECT : DRAIN;
            default: state_d = COLLECT;
        endcase
    end

    // one-entry result register; SeqErr compares with the previously delivered count
    always_ff @(posedge clk) begin
        if (reset) begin
            OutValid <= 1'b0;
            Minstr <= '0;
            InterPacketDelay <= '0;
            FrameCount <= '0;
            SeqErr <= 1'b0;
            first_q <= 1'b1;
        end else if (load) begin
            OutValid <= 1'b1;
            Minstr <= hdr[8*RVVI_MINSTR_OFF +: XLEN];
            InterPacketDelay <= hdr[8*RVVI_IPD_OFF +: 32];
            FrameCount <= fc_new;
            SeqErr <= !first_q && fc_new != FrameCount + FRAME_COUNT_WIDTH'(1);
            first_q <= 1'b0;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

    rvvi_sat_counter #(STAT_WIDTH) u_short (.clk(clk), .reset(reset), .en(short_en), .q(ShortCnt));
    rvvi_sat_counter #(STAT_WIDTH) u_mismatch (.clk(clk), .reset(reset), .en(mismatch_en), .q(MismatchCnt));
    rvvi_sat_counter #(STAT_WIDTH) u_overflow (.clk(clk), .reset(reset), .en(overflow_en), .q(OverflowCnt));
endmodule

// File: tb/tb_rvvi_frame_decoder.sv
// tb_rvvi_frame_decoder: directed and random frames against 32-bit and 64-bit decoders with a frame-level model
module tb_rvvi_frame_decoder;
    import rvvi_frame_decoder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [47:0] dst_mac = 48'h6655_4433_2211;
    logic [47:0] src_mac = 48'h0F0E_0D0C_0B0A;
    logic [15:0] eth_type = 16'h88B5;

    logic [31:0] d32 = '0;
    logic l32 = 1'b0, v32 = 1'b0, r32 = 1'b0;
    logic [63:0] d64 = '0;
    logic l64 = 1'b0, v64 = 1'b0, r64 = 1'b0;

    logic ov32, se32, ov64, se64;
    logic [63:0] mi32, mi64;
    logic [31:0] ip32, ip64;
    logic [15:0] fc32, fc64, sc32, mc32, oc32;
    logic [1:0] sc64, mc64, oc64;

    rvvi_frame_decoder #(.DATA_WIDTH(32), .FRAME_COUNT_WIDTH(16), .STAT_WIDTH(16)) u32 (
        .clk(clk), .reset(reset), .RvviAxiRdata(d32), .RvviAxiRstrb(4'hF), .RvviAxiRlast(l32),
        .RvviAxiRvalid(v32), .DstMac(dst_mac), .SrcMac(src_mac), .EthType(eth_type),
        .OutValid(ov32), .OutReady(r32), .Minstr(mi32), .InterPacketDelay(ip32), .FrameCount(fc32),
        .SeqErr(se32), .ShortCnt(sc32), .MismatchCnt(mc32), .OverflowCnt(oc32));

    rvvi_frame_decoder #(.DATA_WIDTH(64), .FRAME_COUNT_WIDTH(16), .STAT_WIDTH(2)) u64 (
        .clk(clk), .reset(reset), .RvviAxiRdata(d64), .RvviAxiRstrb(8'hFF), .RvviAxiRlast(l64),
        .RvviAxiRvalid(v64), .DstMac(dst_mac), .SrcMac(src_mac), .EthType(eth_type),
        .OutValid(ov64), .OutReady(r64), .Minstr(mi64), .InterPacketDelay(ip64), .FrameCount(fc64),
        .SeqErr(se64), .ShortCnt(sc64), .MismatchCnt(mc64), .OverflowCnt(oc64));

    int checks = 0;
    int failures = 0;

    bit m_valid[2], m_seq[2], m_first[2];
    logic [63:0] m_minstr[2];
    logic [31:0] m_ipd[2];
    logic [15:0] m_fc[2];
    int m_short[2], m_mism[2], m_ovf[2];
    int m_max[2] = '{65535, 3};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 0; m_seq[s] = 0; m_first[s] = 1;
            m_minstr[s] = '0; m_ipd[s] = '0; m_fc[s] = '0;
            m_short[s] = 0; m_mism[s] = 0; m_ovf[s] = 0;
        end
    endtask

    task automatic check_fields(input int s, input string tag);
        chk({tag, ".minstr"}, s ? mi64 : mi32, m_minstr[s]);
        chk({tag, ".ipd"}, s ? 64'(ip64) : 64'(ip32), 64'(m_ipd[s]));
        chk({tag, ".fc"}, s ? 64'(fc64) : 64'(fc32), 64'(m_fc[s]));
        chk({tag, ".seqerr"}, s ? 64'(se64) : 64'(se32), 64'(m_seq[s]));
    endtask

    task automatic check_all(input int s, input string tag);
        chk({tag, ".valid"}, s ? 64'(ov64) : 64'(ov32), 64'(m_valid[s]));
        check_fields(s, tag);
        chk({tag, ".short"}, s ? 64'(sc64) : 64'(sc32), 64'(m_short[s]));
        chk({tag, ".mismatch"}, s ? 64'(mc64) : 64'(mc32), 64'(m_mism[s]));
        chk({tag, ".overflow"}, s ? 64'(oc64) : 64'(oc32), 64'(m_ovf[s]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; v32 = 0; l32 = 0; v64 = 0; l64 = 0;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    // one frame of nb beats; bad >= 0 corrupts that header byte
    task automatic send(input int s, input int nb, input bit rdy, input int bad,
                        input logic [15:0] fc, input logic [63:0] mi, input logic [31:0] ipd);
        byte unsigned fb[128];
        logic [63:0] beat;
        logic [15:0] rfc;
        logic [63:0] rmi;
        logic [31:0] ripd;
        int bpb, hb, ncyc;
        bit ok, dlv, pv;
        bpb = s ? 8 : 4;
        hb = (RVVI_HDR_BYTES + bpb - 1) / bpb;
        for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            fb[i] = dst_mac[8*i +: 8];
            fb[6+i] = src_mac[8*i +: 8];
        end
        for (int i = 0; i < 2; i++) fb[12+i] = eth_type[8*i +: 8];
        for (int i = 0; i < 2; i++) fb[14+i] = fc[8*i +: 8];
        for (int i = 0; i < 8; i++) fb[16+i] = mi[8*i +: 8];
        for (int i = 0; i < 4; i++) fb[24+i] = ipd[8*i +: 8];
        if (bad >= 0) fb[bad] = fb[bad] ^ 8'($urandom_range(255, 1));
        ok = 1;
        for (int i = 0; i < 6; i++)
            if (fb[i] != dst_mac[8*i +: 8] || fb[6+i] != src_mac[8*i +: 8]) ok = 0;
        if ({fb[13], fb[12]} != eth_type) ok = 0;
        rfc = {fb[15], fb[14]};
        rmi = {fb[23], fb[22], fb[21], fb[20], fb[19], fb[18], fb[17], fb[16]};
        ripd = {fb[27], fb[26], fb[25], fb[24]};
        pv = m_valid[s];
        dlv = nb >= hb && ok && !(pv && !rdy);
        if (s) r64 = rdy; else r32 = rdy;
        ncyc = (nb > hb + 1 ? nb : hb + 1) + 2;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            beat = '0;
            for (int j = 0; j < bpb; j++) beat[8*j +: 8] = fb[c*bpb + j];
            if (s) begin d64 = beat; v64 = c < nb; l64 = c == nb - 1; end
            else begin d32 = beat[31:0]; v32 = c < nb; l32 = c == nb - 1; end
            @(posedge clk);
            #1;
            if (c == hb - 1)
                chk("pre_latency.valid", s ? 64'(ov64) : 64'(ov32), 64'(rdy ? 1'b0 : pv));
            if (c == hb) begin
                if (nb < hb) m_short[s] = m_short[s] == m_max[s] ? m_short[s] : m_short[s] + 1;
                else if (!ok) m_mism[s] = m_mism[s] == m_max[s] ? m_mism[s] : m_mism[s] + 1;
                else if (!dlv) m_ovf[s] = m_ovf[s] == m_max[s] ? m_ovf[s] : m_ovf[s] + 1;
                else begin
                    m_seq[s] = !m_first[s] && rfc != 16'(m_fc[s] + 1);
                    m_fc[s] = rfc; m_minstr[s] = rmi; m_ipd[s] = ripd;
                    m_first[s] = 0; m_valid[s] = 1;
                end
                chk("latency.valid", s ? 64'(ov64) : 64'(ov32), 64'(dlv ? 1'b1 : (rdy ? 1'b0 : pv)));
                if (dlv || (!rdy && pv)) check_fields(s, "latency");
            end
        end
        if (rdy) m_valid[s] = 0;
        check_all(s, s ? "frame64" : "frame32");
    endtask

    initial begin
        logic [63:0] mi;
        int s;
        model_reset();
        repeat (3) @(negedge clk);
        check_all(0, "reset32");
        check_all(1, "reset64");
        reset = 0;
        mi = 64'h1234_5678_9ABC_DEF0;

        send(0, 10, 1, -1, 16'd5, mi, 32'd100);
        chk("good32.fc", 64'(fc32), 64'd5);
        chk("good32.minstr", mi32, mi);
        send(1, 4, 1, -1, 16'd5, mi, 32'd100);
        chk("good64.ipd", 64'(ip64), 64'd100);
        send(1, 4, 1, -1, 16'd6, mi + 1, 32'd200);
        chk("next64.fc", 64'(fc64), 64'd6);

        send(0, 5, 1, -1, 16'd6, mi, 32'd1);
        chk("short32.cnt", 64'(sc32), 64'd1);
        send(0, 10, 1, 8, 16'd6, mi, 32'd1);
        chk("mismatch32.cnt", 64'(mc32), 64'd1);

        send(0, 10, 0, -1, 16'd7, mi, 32'd7);
        send(0, 10, 0, -1, 16'd8, mi, 32'd8);
        chk("overflow32.cnt", 64'(oc32), 64'd1);
        chk("overflow32.held_fc", 64'(fc32), 64'd7);
        @(negedge clk); r32 = 1;
        @(negedge clk); r32 = 0;
        m_valid[0] = 0;
        chk("drop32.valid", 64'(ov32), 64'd0);

        do_reset();
        send(0, 9, 1, -1, 16'hFFFF, mi, 32'd3);
        chk("seq_ffff", 64'(se32), 64'd0);
        send(0, 9, 1, -1, 16'h0000, mi, 32'd3);
        chk("seq_0000", 64'(se32), 64'd0);
        send(0, 9, 1, -1, 16'h0002, mi, 32'd3);
        chk("seq_0002", 64'(se32), 64'd1);

        for (int k = 0; k < 4; k++) send(1, 6, 1, 3, 16'd1, mi, 32'd0);
        chk("sat64.mismatch", 64'(mc64), 64'd3);

        for (int k = 0; k < 40; k++) begin
            s = int'($urandom_range(1, 0));
            send(s, int'($urandom_range(12, 1)), 1'($urandom), $urandom_range(3, 0) == 0 ? int'($urandom_range(13, 0)) : -1,
                 $urandom_range(1, 0) == 0 ? 16'(m_fc[s] + 1) : 16'($urandom), {$urandom, $urandom}, $urandom);
        end

        send(0, 10, 0, -1, 16'd9, mi, 32'd9);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            d32 = $urandom; v32 = 1; l32 = 0;
        end
        @(negedge clk);
        reset = 1; v32 = 0;
        @(negedge clk);
        model_reset();
        check_all(0, "reset_drain32");
        check_all(1, "reset_drain64");
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            d32 = $urandom; v32 = 1; l32 = c == 2;
            @(negedge clk);
        end
        v32 = 0; l32 = 0;
        repeat (2) @(negedge clk);
        m_short[0] = 1;
        check_all(0, "tail_short32");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
